// File: rtl/pc_sequencer_if.sv
// Control/status bundle between an instruction decoder and the program-counter sequencer.
interface pc_sequencer_if #(
  parameter int PC_W = 12
);
  logic            start_i;
  logic            stall_i;
  logic            halt_i;
  logic            br_i;
  logic            br_take_i;
  logic            call_i;
  logic            ret_i;
  logic [PC_W-1:0] lut_target_i;
  logic            lut_en_o;
  logic [PC_W-1:0] pc_o;
  logic            running_o;
  logic            done_o;
  logic            err_o;
  logic [1:0]      err_code_o;
  logic [15:0]     icount_o;

  // Decoder side: drives instruction qualifiers, observes sequencing state.
  modport master (
    output start_i, stall_i, halt_i, br_i, br_take_i, call_i, ret_i, lut_target_i,
    input  lut_en_o, pc_o, running_o, done_o, err_o, err_code_o, icount_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, stall_i, halt_i, br_i, br_take_i, call_i, ret_i, lut_target_i,
    output lut_en_o, pc_o, running_o, done_o, err_o, err_code_o, icount_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT control, branch/call/return via LUT targets,
// bounded return stack, sticky first-error capture and saturating retired-instruction count.
module pc_sequencer #(
  parameter int PC_W    = 12,
  parameter int STACK_D = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(STACK_D);
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [1:0] ERR_TARGET = 2'b01;
  localparam logic [1:0] ERR_OVFL   = 2'b10;
  localparam logic [1:0] ERR_UNDF   = 2'b11;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [SP_W-1:0] sp_q;
  logic [15:0]     icount_q;
  logic            err_q;
  logic [1:0]      err_code_q;
  logic            running_q;
  logic            done_q;

  logic [PC_W-1:0] stack_mem [STACK_D];

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_nxt;
  logic [IDX_W-1:0] top_idx;
  logic            stack_empty;
  logic            stack_full;
  logic            do_push;
  logic            do_pop;
  logic            halt_hit;
  logic            err_hit;
  logic [1:0]      err_code_nxt;
  logic            advance;

  assign pc_inc      = pc_q + 1'b1;
  assign top_idx     = IDX_W'(sp_q - 1'b1);
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_W'(STACK_D));
  assign advance     = running_q & ~bus.stall_i;

  // Next-PC decision for an unstalled RUN cycle: halt > ret > call > taken branch > pc+1.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    pc_nxt       = pc_q;
    do_push      = 1'b0;
    do_pop       = 1'b0;
    halt_hit     = 1'b0;
    err_hit      = 1'b0;
    err_code_nxt = 2'b00;
    if (bus.halt_i) begin
      halt_hit = 1'b1;
    end else if (bus.ret_i) begin
      if (stack_empty) begin
        err_hit      = 1'b1;
        err_code_nxt = ERR_UNDF;
      end else begin
        do_pop = 1'b1;
        pc_nxt = stack_mem[top_idx];
      end
    end else if (bus.call_i) begin
      if (bus.lut_target_i == '0) begin
        err_hit      = 1'b1;
        err_code_nxt = ERR_TARGET;
      end else if (stack_full) begin
        err_hit      = 1'b1;
        err_code_nxt = ERR_OVFL;
      end else begin
        do_push = 1'b1;
        pc_nxt  = bus.lut_target_i;
      end
    end else if (bus.br_i && bus.br_take_i) begin
      if (bus.lut_target_i == '0) begin
        err_hit      = 1'b1;
        err_code_nxt = ERR_TARGET;
      end else begin
        pc_nxt = bus.lut_target_i;
      end
    end else if (&pc_q) begin
      // Falling off the top of the address space is treated like an underflow, never a wrap.
      err_hit      = 1'b1;
      err_code_nxt = ERR_UNDF;
    end else begin
      pc_nxt = pc_inc;
    end
  end

  // NOTE: the return stack is plain storage with no reset; the stack pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (advance && do_push) begin
      stack_mem[sp_q[IDX_W-1:0]] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      sp_q       <= '0;
      icount_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (bus.start_i) begin
            state_q    <= RUN;
            pc_q       <= '0;
            sp_q       <= '0;
            icount_q   <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            running_q  <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.stall_i) begin
            if (err_hit) begin
              if (!err_q) begin
                err_q      <= 1'b1;
                err_code_q <= err_code_nxt;
              end
              state_q   <= HALT;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              pc_q <= pc_nxt;
              if (do_push) sp_q <= sp_q + 1'b1;
              if (do_pop)  sp_q <= sp_q - 1'b1;
              if (icount_q != 16'hFFFF) icount_q <= icount_q + 16'd1;
              if (halt_hit) begin
                state_q   <= HALT;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lut_en_o   = running_q & ~bus.stall_i & (bus.br_i | bus.call_i);
  assign bus.pc_o       = pc_q;
  assign bus.running_o  = running_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;
  assign bus.err_code_o = err_code_q;
  assign bus.icount_o   = icount_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (PC_W=12, STACK_D=4).
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pc_sequencer_if #(.PC_W(12)) bus ();

  pc_sequencer #(.PC_W(12), .STACK_D(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    bus.start_i      = 1'b0;
    bus.stall_i      = 1'b0;
    bus.halt_i       = 1'b0;
    bus.br_i         = 1'b0;
    bus.br_take_i    = 1'b0;
    bus.call_i       = 1'b0;
    bus.ret_i        = 1'b0;
    bus.lut_target_i = '0;
  endtask

  // Force HALT if running, restart at pc 0, then retire n plain instructions.
  task automatic launch(input int n);
    bus.halt_i = 1'b1;
    tick();
    bus.halt_i  = 1'b0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear_ctl();
    rst_n = 1'b0;
    #12;
    check("rst_pc",      32'(bus.pc_o), 0);
    check("rst_running", 32'(bus.running_o), 0);
    check("rst_done",    32'(bus.done_o), 0);
    check("rst_err",     32'({bus.err_o, bus.err_code_o}), 0);
    check("rst_icount",  32'(bus.icount_o), 0);
    check("rst_lut_en",  32'(bus.lut_en_o), 0);
    rst_n = 1'b1;
    tick();
    check("idle_hold_pc", 32'(bus.pc_o), 0);
    check("idle_running", 32'(bus.running_o), 0);

    // Start pulse, five plain instructions, then halt.
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("run_entry", 32'(bus.running_o), 1);
    for (int i = 0; i <= 5; i++) begin
      check($sformatf("seq_pc%0d", i), 32'(bus.pc_o), 32'(i));
      if (i < 5) tick();
    end
    bus.halt_i = 1'b1;
    tick();
    bus.halt_i = 1'b0;
    check("halt_pc",      32'(bus.pc_o), 5);
    check("halt_done",    32'(bus.done_o), 1);
    check("halt_running", 32'(bus.running_o), 0);
    check("halt_icount",  32'(bus.icount_o), 6);
    tick();
    check("halt_stays", 32'({bus.done_o, bus.pc_o}), 32'({1'b1, 12'd5}));

    // Taken and not-taken branch from pc 3.
    launch(3);
    check("br_at3", 32'(bus.pc_o), 3);
    bus.br_i = 1'b1; bus.br_take_i = 1'b1; bus.lut_target_i = 12'd18;
    #1;
    check("br_lut_en", 32'(bus.lut_en_o), 1);
    tick();
    clear_ctl();
    check("br_taken_pc", 32'(bus.pc_o), 18);
    launch(3);
    bus.br_i = 1'b1; bus.br_take_i = 1'b0; bus.lut_target_i = 12'd18;
    tick();
    clear_ctl();
    check("br_not_taken_pc", 32'(bus.pc_o), 4);

    // Call at 6 to 52, return to 7.
    launch(6);
    bus.call_i = 1'b1; bus.lut_target_i = 12'd52;
    tick();
    clear_ctl();
    check("call_pc", 32'(bus.pc_o), 52);
    bus.ret_i = 1'b1;
    tick();
    clear_ctl();
    check("ret_pc", 32'(bus.pc_o), 7);
    check("ret_running", 32'(bus.running_o), 1);

    // Five nested calls overflow a 4-deep stack.
    launch(0);
    for (int i = 1; i <= 5; i++) begin
      bus.call_i = 1'b1; bus.lut_target_i = 12'(i * 10);
      tick();
    end
    clear_ctl();
    check("ovf_pc",   32'(bus.pc_o), 40);
    check("ovf_code", 32'({bus.err_o, bus.err_code_o}), 32'(3'b110));
    check("ovf_done", 32'(bus.done_o), 1);

    // Return with an empty stack.
    launch(2);
    bus.ret_i = 1'b1;
    tick();
    clear_ctl();
    check("undf_code",   32'({bus.err_o, bus.err_code_o}), 32'(3'b111));
    check("undf_pc",     32'(bus.pc_o), 2);
    check("undf_icount", 32'(bus.icount_o), 2);

    // Taken branch to unmapped target; error stays sticky in HALT.
    launch(3);
    bus.br_i = 1'b1; bus.br_take_i = 1'b1; bus.lut_target_i = 12'd0;
    tick();
    clear_ctl();
    check("bad_tgt_code", 32'({bus.err_o, bus.err_code_o}), 32'(3'b101));
    check("bad_tgt_pc",   32'(bus.pc_o), 3);
    tick();
    check("err_sticky", 32'({bus.err_o, bus.err_code_o}), 32'(3'b101));
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("err_clear", 32'({bus.err_o, bus.err_code_o, bus.pc_o}), 0);

    // Three stalled cycles hold everything.
    launch(4);
    bus.stall_i = 1'b1; bus.br_i = 1'b1; bus.br_take_i = 1'b1; bus.lut_target_i = 12'd99;
    #1;
    check("stall_lut_en", 32'(bus.lut_en_o), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_pc%0d", i),     32'(bus.pc_o), 4);
      check($sformatf("stall_icount%0d", i), 32'(bus.icount_o), 4);
    end
    clear_ctl();
    tick();
    check("stall_release_pc", 32'(bus.pc_o), 5);

    // Top of address space: no wrap.
    launch(0);
    bus.call_i = 1'b1; bus.lut_target_i = 12'd4094;
    tick();
    clear_ctl();
    tick();
    check("top_pc", 32'(bus.pc_o), 4095);
    tick();
    check("wrap_code", 32'({bus.err_o, bus.err_code_o}), 32'(3'b111));
    check("wrap_pc",   32'(bus.pc_o), 4095);

    // Asynchronous reset mid-RUN, then no progress without start.
    launch(3);
    bus.br_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc",      32'(bus.pc_o), 0);
    check("arst_running", 32'(bus.running_o), 0);
    check("arst_icount",  32'(bus.icount_o), 0);
    check("arst_lut_en",  32'(bus.lut_en_o), 0);
    #4;
    rst_n = 1'b1;
    clear_ctl();
    repeat (3) tick();
    check("arst_idle", 32'({bus.running_o, bus.pc_o}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
